// File: rtl/alu_pkg.sv
// Shared op codes and FSM state codes for the sequential ALU core and the display decode.
package alu_pkg;

  localparam logic [1:0] OP_XNOR  = 2'b00;
  localparam logic [1:0] OP_SHIFT = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;
  localparam logic [1:0] OP_MULT  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MULT = 2'd2
  } state_e;

endpackage

// File: rtl/alu_seq_core_if.sv
// Request/response bundle of the sequential ALU; zero/ovf exist only when ALU_FLAGS_EN is defined.
interface alu_seq_core_if #(
   parameter int unsigned WIDTH = 3
);
   logic                   en;
   logic                   start;
   logic [1:0]             op;
   logic [WIDTH-1:0]       A;
   logic [WIDTH-1:0]       B;
   logic                   busy;
   logic                   done;
   logic [2*WIDTH-1:0]     result;
`ifdef ALU_FLAGS_EN
   logic                   zero;
   logic                   ovf;
`endif

   modport master (
      output en, start, op, A, B,
`ifdef ALU_FLAGS_EN
      input  zero, ovf,
`endif
      input  busy, done, result
   );

   modport slave (
      input  en, start, op, A, B,
`ifdef ALU_FLAGS_EN
      output zero, ovf,
`endif
      output busy, done, result
   );

endinterface

// File: rtl/alu_seq_mult.sv
// Shift-add multiplier datapath: one partial product per step, prod_o is the post-step value.
module alu_seq_mult #(
   parameter int unsigned WIDTH = 3,
   parameter int unsigned CNT_W = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 load_i,
   input  logic                 step_i,
   input  logic [WIDTH-1:0]     a_i,
   input  logic [WIDTH-1:0]     b_i,
   output logic [2*WIDTH-1:0]   prod_o,
   output logic                 last_o
);

   logic [2*WIDTH-1:0] acc_q, acc_d, partial;
   logic [CNT_W-1:0]   count_q, count_d;

   always_comb begin
      partial = a_i[count_q] ? ({{WIDTH{1'b0}}, b_i} << count_q) : '0;
      acc_d   = acc_q;
      count_d = count_q;
      if (load_i) begin
         acc_d   = '0;
         count_d = '0;
      end else if (step_i) begin
         acc_d   = acc_q + partial;
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc_q   <= '0;
         count_q <= '0;
      end else begin
         acc_q   <= acc_d;
         count_q <= count_d;
      end
   end

   // Product including the current iteration, so the FSM can register it on the last step.
   assign prod_o = acc_q + partial;
   assign last_o = (count_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/alu_seq_core.sv
// Handshaked ALU core: XNOR/SHIFT/ADD in one cycle, MULT over WIDTH cycles.
// Define ALU_FLAGS_EN to add registered zero/ovf outputs.
module alu_seq_core #(
   parameter int unsigned WIDTH = 3,
   parameter int unsigned CNT_W = (WIDTH < 2) ? 1 : $clog2(WIDTH)
) (
   input logic           CLK_50,
   input logic           rst,
   alu_seq_core_if.slave bus_io
);
   import alu_pkg::*;

   state_e               state_q;
   logic                 busy_q, done_q;
   logic [2*WIDTH-1:0]   result_q;
   logic [WIDTH-1:0]     a_q, b_q;
   logic [1:0]           op_q;
   logic [WIDTH:0]       sum;
   logic [2*WIDTH-1:0]   exec_res;
   logic [2*WIDTH-1:0]   mult_prod;
   logic                 mult_last, mult_load, mult_step;
`ifdef ALU_FLAGS_EN
   logic                 zero_q, ovf_q;
`endif

   assign sum = {1'b0, a_q} + {1'b0, b_q};

   always_comb begin
      exec_res = '0;
      unique case (op_q)
         OP_XNOR:  exec_res = {{WIDTH{1'b0}}, ~(a_q ^ b_q)};
         OP_SHIFT: exec_res = {{WIDTH{1'b0}}, a_q} << b_q;
         OP_ADD:   exec_res = {{(WIDTH-1){1'b0}}, sum};
         default:  exec_res = '0;
      endcase
   end

   assign mult_load = bus_io.en && (state_q == S_IDLE) && bus_io.start;
   assign mult_step = bus_io.en && (state_q == S_MULT);

   alu_seq_mult #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_mult (
      .clk_i  (CLK_50),
      .rst_i  (rst),
      .load_i (mult_load),
      .step_i (mult_step),
      .a_i    (a_q),
      .b_i    (b_q),
      .prod_o (mult_prod),
      .last_o (mult_last)
   );

   always_ff @(posedge CLK_50 or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= OP_XNOR;
`ifdef ALU_FLAGS_EN
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
`endif
      end else if (bus_io.en) begin
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (bus_io.start) begin
                  a_q     <= bus_io.A;
                  b_q     <= bus_io.B;
                  op_q    <= bus_io.op;
                  busy_q  <= 1'b1;
                  state_q <= (bus_io.op == OP_MULT) ? S_MULT : S_EXEC;
               end
            end
            S_EXEC: begin
               result_q <= exec_res;
               done_q   <= 1'b1;
               busy_q   <= 1'b0;
               state_q  <= S_IDLE;
`ifdef ALU_FLAGS_EN
               zero_q   <= (exec_res == '0);
               ovf_q    <= (op_q == OP_ADD) && sum[WIDTH];
`endif
            end
            S_MULT: begin
               if (mult_last) begin
                  result_q <= mult_prod;
                  done_q   <= 1'b1;
                  busy_q   <= 1'b0;
                  state_q  <= S_IDLE;
`ifdef ALU_FLAGS_EN
                  zero_q   <= (mult_prod == '0);
                  ovf_q    <= |mult_prod[2*WIDTH-1:WIDTH];
`endif
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus_io.busy   = busy_q;
   assign bus_io.done   = done_q;
   assign bus_io.result = result_q;
`ifdef ALU_FLAGS_EN
   assign bus_io.zero   = zero_q;
   assign bus_io.ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_alu_seq_core.sv
// Bench for alu_seq_core: vector table, corner sequences and random ops against an arithmetic model.
module tb_alu_seq_core;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   n_pass  = 0;
   int   n_total = 0;

   always #5 clk = ~clk;

   alu_seq_core_if #(.WIDTH(3)) b3 ();
   alu_seq_core_if #(.WIDTH(8)) b8 ();

   alu_seq_core #(.WIDTH(3)) dut3 (.CLK_50(clk), .rst(rst), .bus_io(b3));
   alu_seq_core #(.WIDTH(8)) dut8 (.CLK_50(clk), .rst(rst), .bus_io(b8));

   typedef struct {
      logic [1:0] op;
      longint     a;
      longint     b;
      longint     exp;
      int         lat;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input longint got, input longint exp);
      n_total++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, got, exp);
   endtask

   function automatic longint ref_res(input int w, input logic [1:0] op, input longint a,
                                      input longint b);
      longint m1 = (longint'(1) << w) - 1;
      longint m2 = (longint'(1) << (2 * w)) - 1;
      case (op)
         OP_XNOR:  return (~(a ^ b)) & m1;
         OP_SHIFT: return (b >= 2 * w) ? 0 : ((a << b) & m2);
         OP_ADD:   return a + b;
         default:  return a * b;
      endcase
   endfunction

   function automatic longint ref_ovf(input int w, input logic [1:0] op, input longint a,
                                      input longint b);
      longint m1 = (longint'(1) << w) - 1;
      if (op == OP_ADD)  return (a + b > m1) ? 1 : 0;
      if (op == OP_MULT) return (a * b > m1) ? 1 : 0;
      return 0;
   endfunction

   function automatic longint get_res(input int sel);
      return (sel == 8) ? longint'(b8.result) : longint'(b3.result);
   endfunction
   function automatic logic get_busy(input int sel);
      return (sel == 8) ? b8.busy : b3.busy;
   endfunction
   function automatic logic get_done(input int sel);
      return (sel == 8) ? b8.done : b3.done;
   endfunction
`ifdef ALU_FLAGS_EN
   function automatic logic get_zero(input int sel);
      return (sel == 8) ? b8.zero : b3.zero;
   endfunction
   function automatic logic get_ovf(input int sel);
      return (sel == 8) ? b8.ovf : b3.ovf;
   endfunction
`endif

   task automatic set_in(input int sel, input logic s, input logic [1:0] op, input longint a,
                         input longint b);
      logic [7:0] a8, bb8;
      a8  = a[7:0];
      bb8 = b[7:0];
      if (sel == 8) begin
         b8.start = s; b8.op = op; b8.A = a8; b8.B = bb8;
      end else begin
         b3.start = s; b3.op = op; b3.A = a8[2:0]; b3.B = bb8[2:0];
      end
   endtask

   // Called at posedge+1; returns at posedge+1 one cycle after the done pulse.
   task automatic run_op(input int sel, input logic [1:0] op, input longint a, input longint b,
                         input longint exp, input int lat, input string name);
      int cyc = 0;
      int busy_cnt = 0;
      set_in(sel, 1'b1, op, a, b);
      @(posedge clk); #1;
      set_in(sel, 1'b0, 2'($urandom), longint'($urandom), longint'($urandom));
      if (get_busy(sel)) busy_cnt++;
      chk({name, " done_low_at_accept"}, longint'(get_done(sel)), 0);
      do begin
         @(posedge clk); #1;
         cyc++;
         if (get_busy(sel)) busy_cnt++;
      end while (!get_done(sel) && cyc < 30);
      chk({name, " latency"}, cyc, lat);
      chk({name, " busy_cycles"}, busy_cnt, lat);
      chk({name, " result"}, get_res(sel), exp);
`ifdef ALU_FLAGS_EN
      chk({name, " zero"}, longint'(get_zero(sel)), (exp == 0) ? 1 : 0);
      chk({name, " ovf"}, longint'(get_ovf(sel)), ref_ovf(sel, op, a, b));
`endif
      @(posedge clk); #1;
      chk({name, " done_pulse_end"}, longint'(get_done(sel)), 0);
      chk({name, " result_hold"}, get_res(sel), exp);
   endtask

   initial begin
      int done_cnt;
      vecs[0] = '{OP_ADD,   5, 3,  8, 1};
      vecs[1] = '{OP_XNOR,  5, 6,  4, 1};
      vecs[2] = '{OP_SHIFT, 3, 2, 12, 1};
      vecs[3] = '{OP_SHIFT, 3, 6,  0, 1};
      vecs[4] = '{OP_MULT,  7, 7, 49, 3};
      vecs[5] = '{OP_MULT,  0, 7,  0, 3};
      vecs[6] = '{OP_SHIFT, 7, 5, 32, 1};
      vecs[7] = '{OP_ADD,   7, 7, 14, 1};
      vecs[8] = '{OP_XNOR,  7, 7,  7, 1};

      rst = 1'b1;
      b3.en = 1'b1; b8.en = 1'b1;
      set_in(3, 1'b0, OP_XNOR, 0, 0);
      set_in(8, 1'b0, OP_XNOR, 0, 0);
      #12;
      chk("reset busy", longint'(b3.busy), 0);
      chk("reset done", longint'(b3.done), 0);
      chk("reset result", get_res(3), 0);
      chk("reset result w8", get_res(8), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 9; i++)
         run_op(3, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat,
                $sformatf("vec%0d", i));

      // start requests during a multiply are dropped
      done_cnt = 0;
      set_in(3, 1'b1, OP_MULT, 2, 3);
      @(posedge clk); #1;
      set_in(3, 1'b1, OP_ADD, 1, 1);
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk); #1;
         if (c == 2) set_in(3, 1'b0, OP_ADD, 1, 1);
         if (c == 3) begin
            chk("ignore done_at_k3", longint'(b3.done), 1);
            chk("ignore result", get_res(3), 6);
         end
         if (b3.done) done_cnt++;
      end
      chk("ignore done_count", done_cnt, 1);
      chk("ignore busy_after", longint'(b3.busy), 0);
      chk("ignore result_hold", get_res(3), 6);

      // reset mid multiply
      set_in(3, 1'b1, OP_MULT, 5, 5);
      @(posedge clk); #1;
      set_in(3, 1'b0, OP_MULT, 5, 5);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("abort busy", longint'(b3.busy), 0);
      chk("abort result", get_res(3), 0);
      #1 rst = 1'b0;
      done_cnt = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (b3.done) done_cnt++;
      end
      chk("abort no_done", done_cnt, 0);
      chk("abort result_after", get_res(3), 0);
      run_op(3, OP_ADD, 1, 1, 2, 1, "post_abort add");

      // enable low for two cycles mid multiply, then a stretched done pulse
      set_in(3, 1'b1, OP_MULT, 6, 5);
      @(posedge clk); #1;
      set_in(3, 1'b0, OP_ADD, 0, 0);
      @(posedge clk); #1;
      b3.en = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("en_low busy_held", longint'(b3.busy), 1);
      b3.en = 1'b1;
      @(posedge clk); #1;
      chk("en_low done_k4", longint'(b3.done), 0);
      @(posedge clk); #1;
      chk("en_low done_k5", longint'(b3.done), 1);
      chk("en_low result", get_res(3), 30);
      b3.en = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("en_low done_stretched", longint'(b3.done), 1);
      b3.en = 1'b1;
      @(posedge clk); #1;
      chk("en_low done_cleared", longint'(b3.done), 0);

      run_op(8, OP_MULT, 255, 255, 65025, 8, "w8 mult max");

      for (int i = 0; i < 40; i++) begin
         logic [1:0] op = 2'($urandom_range(0, 3));
         longint a = longint'($urandom_range(0, 7));
         longint b = longint'($urandom_range(0, 7));
         run_op(3, op, a, b, ref_res(3, op, a, b), (op == OP_MULT) ? 3 : 1,
                $sformatf("rnd3_%0d", i));
      end
      for (int i = 0; i < 12; i++) begin
         logic [1:0] op = 2'($urandom_range(0, 3));
         longint a = longint'($urandom_range(0, 255));
         longint b = longint'($urandom_range(0, 255));
         if (i % 4 == 0) b = longint'($urandom_range(0, 17));
         run_op(8, op, a, b, ref_res(8, op, a, b), (op == OP_MULT) ? 8 : 1,
                $sformatf("rnd8_%0d", i));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
